apb_mem_slave_p: RTL and testbench

Parametrised APB slave with on-chip word memory: configurable data width, depth, fixed wait-state insertion, byte write strobes and error response for out-of-range, misaligned and read-only writes. Sits on the APB peripheral bus as a scratch/config memory target and is the successor to the fixed 2048x32 APB memory slave. Only one transfer is in flight at a time.

---
 rtl/apb_mem_slave_p.sv | 144 ++++++++++++++
 tb/tb_apb_mem_slave_p.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave_p.sv
// apb_mem_slave_p
//   APB slave backed by a DEPTH x DATA_W word memory. Each transfer takes a
//   fixed number of wait states. Byte strobes are supported on writes.
//   Out-of-range, misaligned and read-only writes get an error response.
//   Only one transfer is in flight at a time.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   pselx, penable      APB select / access strobe
//   pwrite              1 = write, 0 = read
//   paddr [ADDR_W]      byte address
//   pwdata [DATA_W]     write data
//   pstrb [DATA_W/8]    byte write strobes
//   prdata [DATA_W]     registered read data
//   pready, pslverror   completion / error, decoded from registers only
module apb_mem_slave_p #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 2048,
   parameter int WAIT_STATES = 0,
   parameter int RO_START    = DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pselx,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W/8-1:0] pstrb,
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverror
);

   localparam int STRB_W = DATA_W / 8;
   localparam int OFF    = $clog2(STRB_W);
   localparam int MW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic                err_q, err_d;
   logic [MW-1:0]       idx_q, idx_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   strb_q, strb_d;
   logic [DATA_W-1:0]   prdata_q, prdata_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Address decode of the incoming setup cycle
   logic [ADDR_W-1:0]   idx_full;
   logic                misaligned;
   logic                setup_err;
   logic                complete;
   logic                mem_we;

   assign idx_full   = paddr >> OFF;
   assign misaligned = (paddr & ADDR_W'(STRB_W - 1)) != '0;
   assign setup_err  = (idx_full >= ADDR_W'(DEPTH)) || misaligned ||
                       (pwrite && (idx_full >= ADDR_W'(RO_START)));

   // pready comes only from state; no input-to-output path
   assign pready    = (state_q == ACCESS) && (cnt_q == 4'd0);
   assign pslverror = pready && err_q;
   assign prdata    = prdata_q;

   assign complete  = pready && pselx && penable;
   // A reset in the completion cycle drops the write
   assign mem_we    = complete && wr_q && !err_q && !rst;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      err_d    = err_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      prdata_d = prdata_q;
      case (state_q)
         IDLE: begin
            // penable already high here means no setup phase; ignore it
            if (pselx && !penable) begin
               state_d = ACCESS;
               cnt_d   = 4'(WAIT_STATES);
               wr_d    = pwrite;
               err_d   = setup_err;
               idx_d   = idx_full[MW-1:0];
               wdata_d = pwdata;
               strb_d  = pstrb;
               if (!pwrite)
                  prdata_d = setup_err ? '0 : mem[idx_full[MW-1:0]];
            end
         end
         ACCESS: begin
            if (!(pselx && penable)) begin
               // Master abandoned the transfer
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         prdata_q <= '0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prdata_q <= prdata_d;
         wr_q     <= wr_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
      end
   end

   // Memory array has no reset; only strobed byte lanes are updated
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (strb_q[b])
               mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Directed bench for apb_mem_slave_p. u0 uses default parameters
// (no wait states, no read-only region); u1 uses WAIT_STATES=3, RO_START=1024.
module tb_apb_mem_slave_p;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  psel;
   logic        penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata0, prdata1;
   logic        pready0, pready1, perr0, perr1;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   apb_mem_slave_p u0 (
      .clk(clk), .rst(rst), .pselx(psel[0]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata0), .pready(pready0), .pslverror(perr0));

   apb_mem_slave_p #(.WAIT_STATES(3), .RO_START(1024)) u1 (
      .clk(clk), .rst(rst), .pselx(psel[1]), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata1), .pready(pready1), .pslverror(perr1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic rdy(input int d);
      return (d == 0) ? pready0 : pready1;
   endfunction

   // One full transfer. rd is prdata after completion, err is pslverror
   // in the completion cycle, waits is the number of access cycles with pready=0.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb,
                       output logic [31:0] rd, output logic err, output int waits);
      @(posedge clk); #1;
      psel = '0; psel[d] = 1'b1; penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
      @(posedge clk); #1;
      penable = 1'b1;
      pwdata = ~wd; pstrb = ~strb;   // ignored after setup
      waits = 0;
      while (!rdy(d) && waits < 40) begin
         @(posedge clk); #1;
         waits++;
      end
      if (waits >= 40) chk("timeout", 32'd1, 32'd0);
      err = (d == 0) ? perr0 : perr1;
      @(posedge clk); #1;
      psel = '0; penable = 1'b0;
      rd = (d == 0) ? prdata0 : prdata1;
   endtask

   logic [31:0] rd, prior;
   logic        err;
   int          w;

   initial begin
      rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pready0", {31'd0, pready0}, 32'd0);
      chk("rst_pready1", {31'd0, pready1}, 32'd0);
      chk("rst_prdata0", prdata0, 32'd0);
      chk("rst_perr0",   {31'd0, perr0}, 32'd0);
      rst = 1'b0;

      // Basic write/read, no wait states
      xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, err, w);
      chk("ws0_wr_waits", w, 32'd0);
      chk("ws0_wr_err", {31'd0, err}, 32'd0);
      xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, err, w);
      chk("ws0_rd_waits", w, 32'd0);
      chk("ws0_rd_err", {31'd0, err}, 32'd0);
      chk("ws0_rd_data", rd, 32'hDEADBEEF);
      #1 chk("idle_pready", {31'd0, pready0}, 32'd0);

      // Byte strobes
      xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'hF, rd, err, w);
      xfer(0, 1'b1, 32'h20, 32'h11223344, 4'h5, rd, err, w);
      xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, err, w);
      chk("strb_data", rd, 32'hAA22CC44);

      // Out-of-range read and misaligned write
      xfer(0, 1'b0, 32'h2000, 32'h0, 4'h0, rd, err, w);
      chk("oor_err", {31'd0, err}, 32'd1);
      chk("oor_waits", w, 32'd0);
      chk("oor_prdata", rd, 32'd0);
      xfer(0, 1'b1, 32'h0, 32'h01020304, 4'hF, rd, err, w);
      xfer(0, 1'b1, 32'h3, 32'hFFFFFFFF, 4'hF, rd, err, w);
      chk("misal_err", {31'd0, err}, 32'd1);
      xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, err, w);
      chk("misal_unchanged", rd, 32'h01020304);

      // Wait states
      xfer(1, 1'b1, 32'h40, 32'h12345678, 4'hF, rd, err, w);
      chk("ws3_wr_waits", w, 32'd3);
      xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, rd, err, w);
      chk("ws3_rd_waits", w, 32'd3);
      chk("ws3_rd_data", rd, 32'h12345678);
      chk("ws3_rd_err", {31'd0, err}, 32'd0);

      // Read-only region starts at idx 1024 (paddr 0x1000)
      xfer(1, 1'b0, 32'h1000, 32'h0, 4'h0, prior, err, w);
      chk("ro_rd_err", {31'd0, err}, 32'd0);
      xfer(1, 1'b1, 32'h1000, 32'h5, 4'hF, rd, err, w);
      chk("ro_wr_err", {31'd0, err}, 32'd1);
      xfer(1, 1'b0, 32'h1000, 32'h0, 4'h0, rd, err, w);
      chk("ro_unchanged", rd, prior);
      xfer(1, 1'b1, 32'hFFC, 32'h5, 4'hF, rd, err, w);
      chk("rw_1023_err", {31'd0, err}, 32'd0);
      xfer(1, 1'b0, 32'hFFC, 32'h0, 4'h0, rd, err, w);
      chk("rw_1023_data", rd, 32'h5);

      // Reset in the 2nd wait cycle of a write drops it
      xfer(1, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF, rd, err, w);
      xfer(1, 1'b0, 32'h80, 32'h0, 4'h0, rd, err, w);
      chk("pre_rst_data", rd, 32'hCAFEF00D);
      @(posedge clk); #1;
      psel = 2'b10; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h80; pwdata = 32'h0BADBEEF; pstrb = 4'hF;
      @(posedge clk); #1; penable = 1'b1;   // wait cycle 1
      @(posedge clk); #1; rst = 1'b1;       // wait cycle 2
      @(posedge clk); #1; rst = 1'b0; psel = '0; penable = 1'b0;
      chk("mid_rst_pready", {31'd0, pready1}, 32'd0);
      chk("mid_rst_prdata", prdata1, 32'd0);
      chk("mid_rst_perr", {31'd0, perr1}, 32'd0);
      // IDLE ignores select+enable without a setup cycle
      psel = 2'b10; penable = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("nosetup_pready", {31'd0, pready1}, 32'd0);
      psel = '0; penable = 1'b0;
      xfer(1, 1'b0, 32'h80, 32'h0, 4'h0, rd, err, w);
      chk("post_rst_data", rd, 32'hCAFEF00D);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
